reel_spin_controller: RTL and testbench

- Initiator/consumer side of the four-reel random generator interface.
- Drives the reel stop-request level and owns the spin, stop and settle sequencing.
- After the generator's staggered stop completes, captures the four 4-bit reel digits, classifies the match pattern and applies payout to a credit counter.
- Sits between the debounced buttons and the random generator top; its outputs feed the display logic.

---
 rtl/reel_pkg.sv | 32 +++
 rtl/reel_spin_controller_if.sv | 27 ++
 rtl/reel_match_classifier.sv | 29 ++
 rtl/reel_spin_controller.sv | 113 +++++++++++
 tb/tb_reel_spin_controller.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/reel_pkg.sv
// Shared types and constants for the four-reel spin controller.
// Holds the FSM state encoding, win codes and payout table.
package reel_pkg;

    localparam int CREDIT_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        SPIN,
        SETTLE,
        EVAL,
        PAYOUT
    } state_t;

    localparam logic [2:0] WIN_NONE     = 3'd0;
    localparam logic [2:0] WIN_PAIR     = 3'd1;
    localparam logic [2:0] WIN_TWO_PAIR = 3'd2;
    localparam logic [2:0] WIN_THREE    = 3'd3;
    localparam logic [2:0] WIN_FOUR     = 3'd4;

    localparam logic [CREDIT_W-1:0] PAY_NONE     = 8'd0;
    localparam logic [CREDIT_W-1:0] PAY_PAIR     = 8'd2;
    localparam logic [CREDIT_W-1:0] PAY_TWO_PAIR = 8'd5;
    localparam logic [CREDIT_W-1:0] PAY_THREE    = 8'd10;
    localparam logic [CREDIT_W-1:0] PAY_FOUR     = 8'd50;

    typedef struct packed {
        logic [2:0]          code;
        logic [CREDIT_W-1:0] pay;
    } match_t;

endpackage

// File: rtl/reel_spin_controller_if.sv
// Link between the spin controller and the four-reel generator.
// The controller drives the stop level and reads the reel digits.
interface reel_spin_controller_if;

    logic       stop_int;
    logic [3:0] rand_num1;
    logic [3:0] rand_num2;
    logic [3:0] rand_num3;
    logic [3:0] rand_num4;

    modport master (
        output stop_int,
        input  rand_num1,
        input  rand_num2,
        input  rand_num3,
        input  rand_num4
    );

    modport slave (
        input  stop_int,
        output rand_num1,
        output rand_num2,
        output rand_num3,
        output rand_num4
    );

endinterface

// File: rtl/reel_match_classifier.sv
// Combinational scoring of four reel digits into win code and payout.
// Equal-pair count over the 6 comparisons is unique per pattern.
module reel_match_classifier
    import reel_pkg::*;
(
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [3:0] d4,
    output match_t     match
);

    logic [2:0] pairs;

    assign pairs = 3'(d1 == d2) + 3'(d1 == d3) + 3'(d1 == d4)
                 + 3'(d2 == d3) + 3'(d2 == d4) + 3'(d3 == d4);

    always_comb begin
        match = '{code: WIN_NONE, pay: PAY_NONE};
        unique case (1'b1)
            (pairs == 3'd6): match = '{code: WIN_FOUR,     pay: PAY_FOUR};
            (pairs == 3'd3): match = '{code: WIN_THREE,    pay: PAY_THREE};
            (pairs == 3'd2): match = '{code: WIN_TWO_PAIR, pay: PAY_TWO_PAIR};
            (pairs == 3'd1): match = '{code: WIN_PAIR,     pay: PAY_PAIR};
            default:         match = '{code: WIN_NONE,     pay: PAY_NONE};
        endcase
    end

endmodule

// File: rtl/reel_spin_controller.sv
// Spin/stop/settle sequencing for the four-reel generator.
// Captures the settled digits, scores them and updates credits.
module reel_spin_controller
    import reel_pkg::*;
#(
    parameter int BET             = 1,
    parameter int INIT_CREDITS    = 20,
    parameter int MIN_SPIN_CYCLES = 64,
    parameter int MAX_SPIN_CYCLES = 2**26,
    parameter int SETTLE_CYCLES   = 410
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  spin_btn,
    input  logic                  stop_btn,
    reel_spin_controller_if.master gen,
    output logic [CREDIT_W-1:0]   credits,
    output logic [CREDIT_W-1:0]   payout,
    output logic [2:0]            win_code,
    output logic                  result_valid,
    output logic                  no_credit,
    output logic                  busy
);

    localparam int CNT_MAX = (MAX_SPIN_CYCLES > SETTLE_CYCLES) ?
                             MAX_SPIN_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t          state;
    state_t          state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [3:0]      cap1, cap2, cap3, cap4;
    match_t          match;
    logic            can_pay;
    logic            stop_ok;
    logic            spin_done;
    logic            settle_done;
    logic [CREDIT_W:0] sum;

    assign can_pay     = credits >= CREDIT_W'(BET);
    assign stop_ok     = stop_btn && (cnt >= CNT_W'(MIN_SPIN_CYCLES));
    assign spin_done   = cnt == CNT_W'(MAX_SPIN_CYCLES - 1);
    assign settle_done = cnt == CNT_W'(SETTLE_CYCLES - 1);
    assign sum         = {1'b0, credits} + {1'b0, match.pay};

    reel_match_classifier u_classifier (
        .d1    (cap1),
        .d2    (cap2),
        .d3    (cap3),
        .d4    (cap4),
        .match (match)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (spin_btn && can_pay) state_nxt = SPIN;
            SPIN:    if (stop_ok || spin_done) state_nxt = SETTLE;
            SETTLE:  if (settle_done) state_nxt = EVAL;
            EVAL:    state_nxt = PAYOUT;
            PAYOUT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gen.stop_int = (state != SPIN);
        busy         = (state != IDLE);
    end

    // Counter restarts on every state change so SPIN and SETTLE both start at 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt          <= '0;
            credits      <= CREDIT_W'(INIT_CREDITS);
            payout       <= '0;
            win_code     <= WIN_NONE;
            result_valid <= 1'b0;
            no_credit    <= 1'b0;
            cap1         <= '0;
            cap2         <= '0;
            cap3         <= '0;
            cap4         <= '0;
        end else begin
            result_valid <= 1'b0;
            no_credit    <= 1'b0;
            if (state == IDLE || state_nxt != state) cnt <= '0;
            else                                     cnt <= cnt + 1'b1;
            if (state == IDLE && spin_btn) begin
                if (can_pay) credits <= credits - CREDIT_W'(BET);
                else         no_credit <= 1'b1;
            end
            if (state == EVAL) begin
                cap1 <= gen.rand_num1;
                cap2 <= gen.rand_num2;
                cap3 <= gen.rand_num3;
                cap4 <= gen.rand_num4;
            end
            if (state == PAYOUT) begin
                credits      <= sum[CREDIT_W] ? '1 : sum[CREDIT_W-1:0];
                payout       <= match.pay;
                win_code     <= match.code;
                result_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reel_spin_controller.sv
// Directed bench for reel_spin_controller with hand-computed results.
// Uses a shortened auto-stop limit so the timeout path is reachable.
module tb_reel_spin_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       spin_btn = 1'b0;
    logic       stop_btn = 1'b0;
    logic [7:0] credits;
    logic [7:0] payout;
    logic [2:0] win_code;
    logic       result_valid;
    logic       no_credit;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    reel_spin_controller_if gen ();

    reel_spin_controller #(
        .MAX_SPIN_CYCLES (200)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .spin_btn     (spin_btn),
        .stop_btn     (stop_btn),
        .gen          (gen),
        .credits      (credits),
        .payout       (payout),
        .win_code     (win_code),
        .result_valid (result_valid),
        .no_credit    (no_credit),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_digits(input int a, input int b, input int c, input int d);
        gen.rand_num1 = 4'(a);
        gen.rand_num2 = 4'(b);
        gen.rand_num3 = 4'(c);
        gen.rand_num4 = 4'(d);
    endtask

    // early: SPIN count at which an ignored stop is pulsed (0 = none)
    task automatic spin_run(input string tag, input int early, input int stop_at,
                            input int pre, input int code, input int pay,
                            input int cred);
        int k;
        spin_btn = 1'b1;
        stop_btn = 1'b1;
        tick();
        spin_btn = 1'b0;
        stop_btn = 1'b0;
        chk({tag, "_debit"}, credits, pre - 1);
        chk({tag, "_busy"}, busy, 1);
        for (int c = 0; c < stop_at; c++) begin
            stop_btn = (early != 0 && c == early);
            tick();
        end
        stop_btn = 1'b0;
        chk({tag, "_spinning"}, gen.stop_int, 0);
        stop_btn = 1'b1;
        tick();
        stop_btn = 1'b0;
        chk({tag, "_settle"}, gen.stop_int, 1);
        k = 0;
        while (k < 600) begin
            tick();
            k++;
            if (result_valid) break;
        end
        chk({tag, "_latency"}, k, 412);
        chk({tag, "_code"}, win_code, code);
        chk({tag, "_payout"}, payout, pay);
        chk({tag, "_credits"}, credits, cred);
        chk({tag, "_idle"}, busy, 0);
        tick();
        chk({tag, "_rv_pulse"}, result_valid, 0);
    endtask

    initial begin
        int hits;
        set_digits(1, 2, 3, 4);
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        chk("rst_credits", credits, 20);
        chk("rst_stop_int", gen.stop_int, 1);
        chk("rst_busy", busy, 0);
        chk("rst_win_code", win_code, 0);
        chk("rst_payout", payout, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_nc", no_credit, 0);

        stop_btn = 1'b1;
        tick();
        stop_btn = 1'b0;
        chk("idle_stop_ignored", busy, 0);

        set_digits(7, 7, 7, 7);
        spin_run("four_a", 10, 100, 20, 4, 50, 69);
        set_digits(3, 5, 3, 5);
        spin_run("two_pair", 0, 64, 69, 2, 5, 73);
        set_digits(1, 1, 2, 3);
        spin_run("pair", 63, 64, 73, 1, 2, 74);
        set_digits(5, 5, 5, 2);
        spin_run("three", 0, 64, 74, 3, 10, 83);
        set_digits(1, 2, 3, 4);
        spin_run("none_a", 0, 64, 83, 0, 0, 82);
        spin_run("none_b", 0, 64, 82, 0, 0, 81);

        set_digits(9, 9, 9, 9);
        spin_run("four_b", 0, 64, 81, 4, 50, 130);
        spin_run("four_c", 0, 64, 130, 4, 50, 179);
        spin_run("four_d", 0, 64, 179, 4, 50, 228);
        spin_run("sat_a", 0, 64, 228, 4, 50, 255);
        spin_run("sat_b", 0, 64, 255, 4, 50, 255);

        spin_btn = 1'b1;
        tick();
        spin_btn = 1'b0;
        repeat (199) tick();
        chk("auto_pre", gen.stop_int, 0);
        tick();
        chk("auto_stop", gen.stop_int, 1);
        chk("auto_busy", busy, 1);
        repeat (100) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_credits", credits, 20);
        chk("mid_rst_stop_int", gen.stop_int, 1);
        hits = 0;
        repeat (450) begin
            tick();
            if (result_valid) hits++;
        end
        chk("mid_rst_no_rv", hits, 0);
        chk("mid_rst_payout", payout, 0);

        set_digits(1, 2, 3, 4);
        for (int i = 0; i < 20; i++)
            spin_run("drain", 0, 64, 20 - i, 0, 0, 19 - i);

        spin_btn = 1'b1;
        tick();
        spin_btn = 1'b0;
        chk("nc_pulse", no_credit, 1);
        chk("nc_busy", busy, 0);
        chk("nc_stop_int", gen.stop_int, 1);
        chk("nc_credits", credits, 0);
        tick();
        chk("nc_pulse_end", no_credit, 0);
        chk("nc_still_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
